// File: rtl/iter_alu.sv
// iter_alu -- multi-cycle ALU for the EX stage.
//
// Single-cycle ops (logic, add/sub, compares, shifts, LUI, DIVU by zero,
// illegal codes) register their results on the edge that accepts start_i.
// MULU and DIVU run one radix-2 step per cycle for WIDTH cycles with busy_o
// high, then pulse done_o.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset (aborts any in-flight op)
//   start_i   launch an operation; ignored while busy_o=1
//   ctrl_i    operation select
//   src1_i    operand A
//   src2_i    operand B (also the shifted operand)
//   shamt_i   shift amount, used modulo WIDTH
//   result_o  primary result (low product / quotient)
//   hi_o      high product / remainder, 0 for other ops
//   zero_o    result_o == 0
//   ovf_o     signed overflow for ADD/SUB
//   div0_o    DIVU with a zero divisor
//   busy_o    iterative op in progress
//   done_o    one-cycle pulse: outputs updated this cycle
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [3:0]                 ctrl_i,
  input  logic [WIDTH-1:0]           src1_i,
  input  logic [WIDTH-1:0]           src2_i,
  input  logic [$clog2(WIDTH)-1:0]   shamt_i,
  output logic [WIDTH-1:0]           result_o,
  output logic [WIDTH-1:0]           hi_o,
  output logic                       zero_o,
  output logic                       ovf_o,
  output logic                       div0_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t           state_r;
  logic [SHW-1:0]   cnt_r;
  logic             is_div_r;
  // acc_r: running high product / partial remainder.
  // lo_r : multiplier shifting out while product bits shift in (MULU), or
  //        dividend shifting out while quotient bits shift in (DIVU).
  // opa_r: multiplicand (MULU) or divisor (DIVU).
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opa_r;

  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] sc_result_s;
  logic [WIDTH-1:0] sc_hi_s;
  logic             sc_ovf_s;
  logic             sc_div0_s;
  logic             sc_iter_s;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_sh_s;
  logic [WIDTH+1:0] div_diff_s;
  logic [WIDTH-1:0] step_acc_s;
  logic [WIDTH-1:0] step_lo_s;

  assign add_s = src1_i + src2_i;
  assign sub_s = src1_i - src2_i;

  // Single-cycle result selection from the live inputs (captured on accept).
  always_comb begin
    sc_result_s = {WIDTH{1'b0}};
    sc_hi_s     = {WIDTH{1'b0}};
    sc_ovf_s    = 1'b0;
    sc_div0_s   = 1'b0;
    sc_iter_s   = 1'b0;
    case (ctrl_i)
      OP_AND: sc_result_s = src1_i & src2_i;
      OP_OR:  sc_result_s = src1_i | src2_i;
      OP_ADD: begin
        sc_result_s = add_s;
        sc_ovf_s    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                      (add_s[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result_s = sub_s;
        sc_ovf_s    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                      (sub_s[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OP_SLL:  sc_result_s = src2_i << shamt_i;
      OP_SRL:  sc_result_s = src2_i >> shamt_i;
      OP_SRA:  sc_result_s = $unsigned($signed(src2_i) >>> shamt_i);
      OP_LUI:  sc_result_s = {src2_i[15:0], {(WIDTH-16){1'b0}}};
      OP_MULU: sc_iter_s   = 1'b1;
      OP_DIVU: begin
        if (src2_i == {WIDTH{1'b0}}) begin
          // Divide by zero resolves immediately, RISC-V style.
          sc_result_s = {WIDTH{1'b1}};
          sc_hi_s     = src1_i;
          sc_div0_s   = 1'b1;
        end else begin
          sc_iter_s = 1'b1;
        end
      end
      default: sc_result_s = {WIDTH{1'b0}};
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_r, lo_r[WIDTH-1]};
    // Extra top bit acts as the borrow flag of the trial subtraction.
    div_diff_s = {1'b0, div_sh_s} - {2'b00, opa_r};
    if (is_div_r) begin
      if (div_diff_s[WIDTH+1]) begin
        step_acc_s = div_sh_s[WIDTH-1:0];
        step_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
      end else begin
        step_acc_s = div_diff_s[WIDTH-1:0];
        step_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_acc_s = mul_sum_s[WIDTH:1];
      step_lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= {SHW{1'b0}};
      is_div_r <= 1'b0;
      acc_r    <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      opa_r    <= {WIDTH{1'b0}};
      result_o <= {WIDTH{1'b0}};
      hi_o     <= {WIDTH{1'b0}};
      zero_o   <= 1'b0;
      ovf_o    <= 1'b0;
      div0_o   <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            if (sc_iter_s) begin
              state_r  <= ITER;
              busy_o   <= 1'b1;
              cnt_r    <= {SHW{1'b0}};
              is_div_r <= (ctrl_i == OP_DIVU);
              acc_r    <= {WIDTH{1'b0}};
              opa_r    <= (ctrl_i == OP_DIVU) ? src2_i : src1_i;
              lo_r     <= (ctrl_i == OP_DIVU) ? src1_i : src2_i;
            end else begin
              result_o <= sc_result_s;
              hi_o     <= sc_hi_s;
              zero_o   <= (sc_result_s == {WIDTH{1'b0}});
              ovf_o    <= sc_ovf_s;
              div0_o   <= sc_div0_s;
              done_o   <= 1'b1;
            end
          end
        end
        ITER: begin
          acc_r <= step_acc_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
          if (cnt_r == SHW'(WIDTH-1)) begin
            // Both algorithms leave the low word in lo and the high word in acc.
            state_r  <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= step_lo_s;
            hi_o     <= step_acc_s;
            zero_o   <= (step_lo_s == {WIDTH{1'b0}});
            ovf_o    <= 1'b0;
            div0_o   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
